sram_access_ctrl: RTL and testbench

Cycle-level access sequencer for the sram_4kb_256x128x8 macro (256 rows x 128 bitline pairs, 8:1 column mux, 16-bit word).
- Accepts one read or write request at a time over a valid/ready handshake.
- Drives the macro phases in order: precharge, column select, wordline, write_en, sense_en.
- Returns read data on a one-cycle response pulse.
- Sits between the convolution engine's memory port and the SRAM macro. It is the only block that toggles the macro's wordline, write_en and sense_en.

---
 rtl/sram_access_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
//   Cycle-level access sequencer for the sram_4kb_256x128x8 macro. Accepts one
//   read or write at a time over valid/ready and steps the macro through
//   precharge, column select, wordline, write_en and sense_en. It is the only
//   block that toggles wl_en, write_en and sense_en.
//
//   Build option: define SRAM_CTRL_RMW_EN to add byte-masked writes
//   (req_wmask). A partial mask runs a read pass into an internal merge
//   register, then a write pass with byte-merged bl_wdata. An all-zero mask
//   walks the write sequence with write_en/wl_en held low.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   req_valid/req_ready   request handshake; req_ready only in IDLE
//   req_we/addr/wdata     request fields, captured at acceptance
//   req_wmask             byte write mask (SRAM_CTRL_RMW_EN only)
//   rsp_valid/rsp_rdata   one-cycle completion pulse, read data (held)
//   precharge_n           active-low bitline precharge
//   row_addr, col_sel     wordline address, one-hot column mux select
//   wl_en, write_en,      macro phase enables
//   sense_en
//   bl_wdata, sa_rdata    write-driver data out, sense-amp data in

module sram_access_ctrl #(
   parameter int ROWS    = 256,
   parameter int COL_MUX = 8,
   parameter int WORD_W  = 16,
   parameter int PRE_CYC = 2,
   parameter int DEV_CYC = 2,
   parameter int WR_CYC  = 2,
   localparam int ROW_W  = $clog2(ROWS),
   localparam int COL_W  = $clog2(COL_MUX),
   localparam int ADDR_W = ROW_W + COL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
`ifdef SRAM_CTRL_RMW_EN
   input  logic [WORD_W/8-1:0] req_wmask,
`endif
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              precharge_n,
   output logic [ROW_W-1:0]  row_addr,
   output logic              wl_en,
   output logic [COL_MUX-1:0] col_sel,
   output logic              write_en,
   output logic              sense_en,
   output logic [WORD_W-1:0] bl_wdata,
   input  logic [WORD_W-1:0] sa_rdata
);

   localparam int MAX_CYC = (PRE_CYC > DEV_CYC) ?
                            ((PRE_CYC > WR_CYC) ? PRE_CYC : WR_CYC) :
                            ((DEV_CYC > WR_CYC) ? DEV_CYC : WR_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_WSETUP, S_WRITE, S_DEV, S_SENSE, S_RECOV
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic [WORD_W-1:0]   rdata_q, rdata_d;
   logic                wr_act;     // write pass actually drives the array
   logic                rd_pass;    // next PRE leads into DEV rather than WSETUP

`ifdef SRAM_CTRL_RMW_EN
   logic [WORD_W/8-1:0] wmask_q, wmask_d;
   logic [WORD_W-1:0]   merge_q, merge_d;
   logic                rmw_rd_q, rmw_rd_d;  // read half of a partial-mask write pending
`endif

   // ---------------- state / data registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
`ifdef SRAM_CTRL_RMW_EN
         wmask_q  <= '0;
         merge_q  <= '0;
         rmw_rd_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         row_q    <= row_d;
         col_q    <= col_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
`ifdef SRAM_CTRL_RMW_EN
         wmask_q  <= wmask_d;
         merge_q  <= merge_d;
         rmw_rd_q <= rmw_rd_d;
`endif
      end
   end

`ifdef SRAM_CTRL_RMW_EN
   assign wr_act  = |wmask_q;
   assign rd_pass = !we_q || rmw_rd_q;
`else
   assign wr_act  = 1'b1;
   assign rd_pass = !we_q;
`endif

   // ---------------- next-state ----------------
   // cnt_q holds remaining cycles minus one; every transition reloads it.
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      we_d    = we_q;
      row_d   = row_q;
      col_d   = col_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef SRAM_CTRL_RMW_EN
      wmask_d  = wmask_q;
      merge_d  = merge_q;
      rmw_rd_d = rmw_rd_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_PRE;
               cnt_d   = CNT_W'(PRE_CYC - 1);
               we_d    = req_we;
               row_d   = req_addr[ADDR_W-1:COL_W];
               col_d   = req_addr[COL_W-1:0];
               wdata_d = req_wdata;
`ifdef SRAM_CTRL_RMW_EN
               wmask_d  = req_wmask;
               rmw_rd_d = req_we && (req_wmask != '0) && (req_wmask != '1);
`endif
            end
         end
         S_PRE: begin
            if (cnt_q == '0) begin
               if (rd_pass) begin
                  state_d = S_DEV;
                  cnt_d   = CNT_W'(DEV_CYC - 1);
               end else begin
                  state_d = S_WSETUP;
                  cnt_d   = '0;
               end
            end
         end
         S_WSETUP: begin
            state_d = S_WRITE;
            cnt_d   = CNT_W'(WR_CYC - 1);
         end
         S_WRITE: begin
            if (cnt_q == '0) begin
               state_d = S_RECOV;
               cnt_d   = '0;
            end
         end
         S_DEV: begin
            if (cnt_q == '0) begin
               state_d = S_SENSE;
               cnt_d   = '0;
            end
         end
         S_SENSE: begin
`ifdef SRAM_CTRL_RMW_EN
            if (rmw_rd_q) begin
               // read half done: bitlines need a fresh precharge before writing
               merge_d  = sa_rdata;
               rmw_rd_d = 1'b0;
               state_d  = S_PRE;
               cnt_d    = CNT_W'(PRE_CYC - 1);
            end else begin
               rdata_d = sa_rdata;
               state_d = S_RECOV;
               cnt_d   = '0;
            end
`else
            rdata_d = sa_rdata;
            state_d = S_RECOV;
            cnt_d   = '0;
`endif
         end
         S_RECOV: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------- outputs ----------------
   // Pure decode of state_q so the async reset drops every enable at once.
   always_comb begin
      req_ready   = (state_q == S_IDLE) && !rst;
      precharge_n = !((state_q == S_IDLE) || (state_q == S_PRE));
      wl_en       = ((state_q == S_WRITE) && wr_act) ||
                    (state_q == S_DEV) || (state_q == S_SENSE);
      write_en    = ((state_q == S_WSETUP) || (state_q == S_WRITE)) && wr_act;
      sense_en    = (state_q == S_SENSE);
      rsp_valid   = (state_q == S_RECOV);
      rsp_rdata   = rdata_q;
      row_addr    = row_q;
      col_sel     = (state_q == S_IDLE) ? '0 : (COL_MUX'(1) << col_q);
`ifdef SRAM_CTRL_RMW_EN
      bl_wdata    = merge_q;
      for (int b = 0; b < WORD_W/8; b++)
         if (wmask_q[b]) bl_wdata[b*8 +: 8] = wdata_q[b*8 +: 8];
`else
      bl_wdata    = wdata_q;
`endif
   end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: default instance with a behavioural
// macro model, plus a PRE_CYC=1/DEV_CYC=4 instance for the long-develop read.
module tb_sram_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   // default instance
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [10:0] req_addr  = '0;
   logic [15:0] req_wdata = '0;
   logic        req_ready, rsp_valid, precharge_n, wl_en, write_en, sense_en;
   logic [15:0] rsp_rdata, bl_wdata, sa_rdata;
   logic [7:0]  row_addr, col_sel;

   // long-develop instance
   logic        req_valid2 = 1'b0;
   logic        req_ready2, rsp_valid2, precharge_n2, wl_en2, write_en2, sense_en2;
   logic [15:0] rsp_rdata2, bl_wdata2, sa_rdata2;
   logic [7:0]  row_addr2, col_sel2;

   sram_access_ctrl u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SRAM_CTRL_RMW_EN
      .req_wmask(2'b11),
`endif
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .precharge_n(precharge_n), .row_addr(row_addr), .wl_en(wl_en),
      .col_sel(col_sel), .write_en(write_en), .sense_en(sense_en),
      .bl_wdata(bl_wdata), .sa_rdata(sa_rdata)
   );

   sram_access_ctrl #(.PRE_CYC(1), .DEV_CYC(4)) u_dut2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_we(1'b0),
      .req_addr(11'h123), .req_wdata(16'h0000),
`ifdef SRAM_CTRL_RMW_EN
      .req_wmask(2'b11),
`endif
      .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
      .precharge_n(precharge_n2), .row_addr(row_addr2), .wl_en(wl_en2),
      .col_sel(col_sel2), .write_en(write_en2), .sense_en(sense_en2),
      .bl_wdata(bl_wdata2), .sa_rdata(sa_rdata2)
   );

   // macro model: array written at the edge closing a wl_en&&write_en cycle
   logic [15:0] mem [0:2047];
   logic [2:0]  col_idx;
   always_comb begin
      col_idx = 3'd0;
      for (int i = 0; i < 8; i++) if (col_sel[i]) col_idx = 3'(i);
   end
   always @(posedge clk) if (wl_en && write_en) mem[{row_addr, col_idx}] <= bl_wdata;
   assign sa_rdata  = sense_en  ? mem[{row_addr, col_idx}] : 16'h0000;
   assign sa_rdata2 = sense_en2 ? 16'h5A5A : 16'h0000;

   int n_tests = 0, n_fail = 0, viol = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // phase-ordering invariants, sampled mid-cycle
   always @(negedge clk) if (!rst) begin
      if (sense_en && write_en)    viol++;
      if (wl_en && !precharge_n)   viol++;
      if (sense_en2 && write_en2)  viol++;
      if (wl_en2 && !precharge_n2) viol++;
   end

   // One access on the default instance. exp_rd is the rsp_rdata expected
   // after completion (unchanged value for writes).
   task automatic access(input logic we, input logic [10:0] addr, input logic [15:0] wd,
                         input int exp_lat, input logic [15:0] exp_rd,
                         input logic [7:0] exp_row, input logic [7:0] exp_col);
      int cyc, we_first, wl_first;
      @(negedge clk);
      chk("ready_idle", req_ready, 1'b1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 1; we_first = -1; wl_first = -1;
      chk("row_addr", row_addr, exp_row);
      chk("col_sel", col_sel, exp_col);
      while (!rsp_valid && cyc < 50) begin
         if (write_en && we_first < 0) we_first = cyc;
         if (wl_en && wl_first < 0)    wl_first = cyc;
         @(posedge clk); #1; cyc++;
      end
      chk(we ? "wr_latency" : "rd_latency", cyc, exp_lat);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      if (we) chk("we_lead_wl", wl_first - we_first, 1);
      @(posedge clk); #1;
      chk("rsp_pulse", rsp_valid, 1'b0);
   endtask

   initial begin
      int accepts, pulses, busy_rdy, acc2_at, cyc, wl_cnt, s_cyc, wl_last;
      for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;

      // reset state
      #3;
      chk("rst_ready", req_ready, 1'b0);
      chk("rst_enables", {wl_en, write_en, sense_en, rsp_valid, precharge_n}, 5'b0);
      chk("rst_col_row", {col_sel, row_addr}, 16'h0000);
      chk("rst_data", {bl_wdata, rsp_rdata}, 32'h0);
      @(negedge clk); @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst", {req_ready, precharge_n, col_sel}, {1'b1, 1'b0, 8'h00});

      // write/read at the top corner, then other addresses
      access(1'b1, 11'h7FF, 16'hA5C3, 6, 16'h0000, 8'd255, 8'h80);
      access(1'b0, 11'h7FF, 16'h0000, 6, 16'hA5C3, 8'd255, 8'h80);
      access(1'b1, 11'h000, 16'h1111, 6, 16'hA5C3, 8'd0,   8'h01);
      access(1'b1, 11'h123, 16'hBEEF, 6, 16'hA5C3, 8'h24,  8'h08);
      access(1'b0, 11'h000, 16'h0000, 6, 16'h1111, 8'd0,   8'h01);
      access(1'b0, 11'h123, 16'h0000, 6, 16'hBEEF, 8'h24,  8'h08);
      access(1'b0, 11'h3C5, 16'h0000, 6, 16'h0000, 8'h78,  8'h20);

      // PRE_CYC=1, DEV_CYC=4 read on the second instance
      @(negedge clk); req_valid2 = 1'b1;
      @(posedge clk); #1; req_valid2 = 1'b0;
      cyc = 1; wl_cnt = 0; s_cyc = -1; wl_last = -1;
      while (!rsp_valid2 && cyc < 50) begin
         if (wl_en2) begin wl_cnt++; wl_last = cyc; end
         if (sense_en2) s_cyc = cyc;
         @(posedge clk); #1; cyc++;
      end
      chk("dev4_latency", cyc, 7);
      chk("dev4_wl_cycles", wl_cnt, 5);
      chk("dev4_sense_last", s_cyc, wl_last);
      chk("dev4_rdata", rsp_rdata2, 16'h5A5A);

      // req_valid held through two back-to-back reads
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h7FF;
      accepts = 0; pulses = 0; busy_rdy = 0; acc2_at = -1;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         if (req_ready && req_valid) begin
            accepts++;
            if (accepts == 2) acc2_at = i;
         end else if (req_valid && req_ready) busy_rdy++;
         if (((i >= 1 && i <= 6) || (i >= 8 && i <= 13)) && req_ready) busy_rdy++;
         @(posedge clk); #1;
         if (accepts == 2) req_valid = 1'b0;
         if (rsp_valid) pulses++;
      end
      chk("b2b_accepts", accepts, 2);
      chk("b2b_second_at", acc2_at, 7);
      chk("b2b_pulses", pulses, 2);
      chk("b2b_busy_ready", busy_rdy, 0);

      // reset during WRITE
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h055; req_wdata = 16'h7777;
      @(posedge clk); #1; req_valid = 1'b0;
      cyc = 0;
      while (!wl_en && cyc < 20) begin @(posedge clk); #1; cyc++; end
      chk("in_write", {wl_en, write_en}, 2'b11);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_drop", {wl_en, write_en, sense_en}, 3'b000);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin @(negedge clk); rst = 1'b0; end
         @(posedge clk); #1;
         if (rsp_valid) pulses++;
      end
      chk("rst_no_rsp", pulses, 0);
      access(1'b0, 11'h055, 16'h0000, 6, 16'h0000, 8'h0A, 8'h20);
      access(1'b0, 11'h7FF, 16'h0000, 6, 16'hA5C3, 8'd255, 8'h80);

      chk("invariants", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
